// File: rtl/simon_pkg.sv
// ============================================================================
// Module      : simon_pkg
// Description : Shared button constants and types for the Simon Says game.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package simon_pkg;

    localparam int NUM_BUTTONS = 4;

    typedef logic [$clog2(NUM_BUTTONS)-1:0] button_idx_t;

    typedef enum logic [1:0] {
        BTN_GREEN  = 2'd0,
        BTN_RED    = 2'd1,
        BTN_YELLOW = 2'd2,
        BTN_BLUE   = 2'd3
    } button_e;

endpackage

`default_nettype wire

// File: rtl/press_fifo.sv
// ============================================================================
// Module      : press_fifo
// Description : Small synchronous FIFO with flush, used to queue button presses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module press_fifo
    import simon_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = $bits(button_idx_t)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));
    assign head  = r_mem[r_rd_ptr];

    // A pop frees the slot the same cycle, so a full FIFO can still accept a push.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/button_press_arbiter.sv
// ============================================================================
// Module      : button_press_arbiter
// Description : Round-robin arbiter with post-press lockout feeding a press FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_press_arbiter #(
    parameter int NUM_BUTTONS    = simon_pkg::NUM_BUTTONS,
    parameter int LOCKOUT_CYCLES = 500000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                           clock_signal,
    input  logic                           reset_signal_n,
    input  logic [NUM_BUTTONS-1:0]         press_pulse,
    input  logic                           enable,
    output logic                           press_valid,
    output logic [$clog2(NUM_BUTTONS)-1:0] press_index,
    input  logic                           press_ready,
    output logic                           lockout_active,
    output logic                           overflow,
    input  logic                           clear_overflow
);

    localparam int IDX_W  = $clog2(NUM_BUTTONS);
    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LOCK_W-1:0] C_LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES);
    localparam logic [IDX_W-1:0]  C_LAST_IDX  = IDX_W'(NUM_BUTTONS - 1);

    logic [IDX_W-1:0]  r_rr_ptr;
    logic [LOCK_W-1:0] r_lock_cnt;
    logic              r_overflow;
    logic [IDX_W-1:0]  w_winner;
    logic              w_found;
    logic              w_accept;
    logic              w_pop;
    logic              w_ovf_set;
    logic              w_fifo_full;
    logic              w_fifo_empty;

    // Search upward from the round-robin pointer, wrapping modulo NUM_BUTTONS.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_BUTTONS; k++) begin
            int idx;
            idx = (int'(r_rr_ptr) + k) % NUM_BUTTONS;
            if (!w_found && press_pulse[IDX_W'(idx)]) begin
                w_found  = 1'b1;
                w_winner = IDX_W'(idx);
            end
        end
    end

    assign w_accept  = enable && (r_lock_cnt == '0) && w_found;
    assign w_pop     = !w_fifo_empty && press_ready;
    assign w_ovf_set = w_accept && w_fifo_full && !w_pop;

    always_ff @(posedge clock_signal or negedge reset_signal_n) begin
        if (!reset_signal_n) begin
            r_rr_ptr   <= '0;
            r_lock_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rr_ptr <= (w_winner == C_LAST_IDX) ? '0 : w_winner + 1'b1;
            end

            if (!enable) begin
                r_lock_cnt <= '0;
            end else if (w_accept) begin
                r_lock_cnt <= C_LOCK_LOAD;
            end else if (r_lock_cnt != '0) begin
                r_lock_cnt <= r_lock_cnt - 1'b1;
            end

            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    press_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (IDX_W)
    ) u_press_fifo (
        .clk       (clock_signal),
        .rst_n     (reset_signal_n),
        .flush     (!enable),
        .push      (w_accept),
        .push_data (w_winner),
        .pop       (w_pop),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .head      (press_index)
    );

    assign press_valid    = !w_fifo_empty;
    assign lockout_active = (r_lock_cnt != '0);
    assign overflow       = r_overflow;

endmodule

`default_nettype wire

// File: doc/button_press_arbiter.md
Name: button_press_arbiter

Overview:
- Arbitrates the four synchronized one-cycle button-press pulses (one synchronizer/edge-detector per button) into a single ordered stream of press events for the Simon Says game FSM.
- Resolves simultaneous presses by round-robin and enforces a post-press lockout window against bounce and double presses.
- Buffers accepted presses in a small FIFO and delivers them over a valid/ready handshake.
- Sits between the per-button synchronizers and the game controller's input-compare phase.

Parameters:
- NUM_BUTTONS, 4, number of requesters (pulse inputs).
- LOCKOUT_CYCLES, 500000, cycles after an accepted press during which all pulses are ignored (10 ms at 50 MHz); must be >= 1.
- FIFO_DEPTH, 4, press buffer entries; must be a power of two >= 2.

Ports:
- clock_signal  in  1  system clock; all logic on rising edge.
- reset_signal_n  in  1  asynchronous, active-low reset.
- press_pulse  in  NUM_BUTTONS  one-cycle press pulses, already synchronized to clock_signal.
- enable  in  1  high while the game is accepting player input.
- press_valid  out  1  FIFO non-empty.
- press_index  out  $clog2(NUM_BUTTONS)  button index at the FIFO head; valid only while press_valid is high.
- press_ready  in  1  consumer accepts the head entry this cycle.
- lockout_active  out  1  lockout counter non-zero.
- overflow  out  1  sticky; a winning press was discarded because the FIFO was full.
- clear_overflow  in  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync release): FIFO empty, rr_ptr=0, lockout counter=0, overflow=0. Resulting outputs: press_valid=0, press_index=0, lockout_active=0, overflow=0.
- Candidate condition: in a cycle with enable=1, lockout counter==0 and press_pulse!=0, exactly one winner is chosen.
- Winner selection: the first set bit found searching upward from rr_ptr, wrapping modulo NUM_BUTTONS.
- Losing pulses in the same cycle are discarded, not queued.
- On a winner: rr_ptr <= (winner+1) mod NUM_BUTTONS; lockout counter <= LOCKOUT_CYCLES; winner index is written to the FIFO.
- Lockout counter decrements by 1 each cycle while non-zero. Pulses arriving while it is non-zero are ignored entirely, with no rr_ptr change.
- A new winner is possible in the cycle the counter reads 0, i.e. LOCKOUT_CYCLES+1 cycles after the previous accept.
- Latency: pulse at edge N produces press_valid=1 with the correct index after edge N+1 (registered write). press_index is driven combinationally from the head entry.
- Pop occurs on press_valid && press_ready. press_ready while empty has no effect.
- Full FIFO with no pop: the winner is dropped and overflow<=1. Lockout and rr_ptr still update as for an accepted press.
- Full FIFO with a simultaneous pop: push and pop both occur, the count is unchanged, and overflow is not set.
- Empty FIFO with a simultaneous push: the entry is written; press_valid rises the next cycle. There is no same-cycle bypass.
- enable=0: FIFO flushed (count=0), lockout counter cleared, pulses ignored. rr_ptr and overflow are retained. Flush takes precedence over push and pop.
- clear_overflow: clears overflow next edge. If a new overflow occurs in the same cycle, the set wins.
- Pointer wrap: FIFO read/write pointers are $clog2(FIFO_DEPTH) bits with natural wrap. The full/empty distinction uses a separate count of $clog2(FIFO_DEPTH)+1 bits.
- Lockout counter width: $clog2(LOCKOUT_CYCLES+1) bits; it never underflows.
- Reset mid-operation: immediate return to reset values, including discarding all FIFO contents.

Decomposition:
- simon_pkg holds:
  - NUM_BUTTONS constant.
  - button_idx_t typedef of $clog2(NUM_BUTTONS) bits.
  - Enum button_e {BTN_GREEN=0, BTN_RED=1, BTN_YELLOW=2, BTN_BLUE=3}, shared with the game FSM and LED driver.
- One sub-module, press_fifo: synchronous FIFO with push, pop, flush, full, empty and head data, parameterised by depth and width.
- Round-robin select and lockout counter stay in the top level.

Test Plan (LOCKOUT_CYCLES=8, FIFO_DEPTH=4, enable=1 unless stated):
- Single press: pulse bit 2 at edge 10, ready=1 -> press_valid=1 with press_index=2 for one cycle after edge 11; lockout_active=1 for 8 cycles; rr_ptr=3.
- Simultaneous press: from reset, pulse=4'b1010 -> winner 1, then rr_ptr=2. After lockout, pulse=4'b1010 -> winner 3. After lockout again, pulse=4'b1010 -> winner 1. Each time the loser is not queued.
- Lockout: pulse bit 0 at edge 10, pulse bit 1 at edges 14 and 18 -> only index 0 queued. A pulse at edge 19 is accepted as index 1.
- Overflow: ready=0, five presses spaced 9 cycles apart -> FIFO holds 4 entries in press order, overflow=1. Then clear_overflow for one cycle -> overflow=0 and the FIFO is unchanged.
- Full with simultaneous push and pop: FIFO full, ready=1 in the same cycle as an accepted press -> count stays 4, overflow stays 0, head advances.
- Flush and reset: 3 entries queued, enable=0 for one cycle -> press_valid=0 next cycle. Queue 2 entries, assert reset_signal_n=0 mid-lockout -> press_valid, lockout_active and overflow all 0 immediately, without waiting for a clock edge.
